// File: rtl/instr_sequencer.sv
// instr_sequencer: fetch/decode/execute controller owning PC and IR.
// Ports: clk/rst, imem req/addr/valid/data, instr to ID, ID bs/ps/rw/mw,
//        datapath zero/br_off/bus_a, dmem_ready, exec/rw/mw strobes,
//        halt_req/halted, pc.
module instr_sequencer #(
    parameter int              PC_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_valid,
    input  logic [16:0]     imem_data,
    output logic [16:0]     instr,
    input  logic [1:0]      bs,
    input  logic            ps,
    input  logic            zero,
    input  logic [PC_W-1:0] br_off,
    input  logic [PC_W-1:0] bus_a,
    input  logic            rw,
    input  logic            mw,
    input  logic            dmem_ready,
    output logic            exec_en,
    output logic            rw_en,
    output logic            mw_en,
    input  logic            halt_req,
    output logic            halted,
    output logic [PC_W-1:0] pc
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_HALT
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [16:0]     ir;
    logic [PC_W-1:0] next_pc;
    logic [PC_W-1:0] pc_inc;
    logic [PC_W-1:0] pc_br;
    logic            complete;

    assign pc_inc = pc + PC_W'(1);
    assign pc_br  = pc + br_off;

    // A memory write that the data memory has not accepted stalls EXEC.
    assign complete = (state == S_EXEC) && !(mw && !dmem_ready);

    always_comb begin
        next_pc = pc_inc;
        unique case (bs)
            2'b00: next_pc = pc_inc;
            2'b01: next_pc = (zero ^ ps) ? pc_br : pc_inc;
            2'b10: next_pc = bus_a;
            2'b11: next_pc = pc_br;
            default: next_pc = pc_inc;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            pc    <= RESET_PC;
            ir    <= '0;
        end else begin
            state <= state_nx;
            if (state == S_FETCH && imem_valid)
                ir <= imem_data;
            if (complete)
                pc <= next_pc;
        end
    end

    always_comb begin
        state_nx  = state;
        imem_req  = 1'b0;
        exec_en   = 1'b0;
        rw_en     = 1'b0;
        mw_en     = 1'b0;
        halted    = 1'b0;
        unique case (state)
            S_IDLE: begin
                state_nx = halt_req ? S_HALT : S_FETCH;
            end
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_valid)
                    state_nx = S_DECODE;
            end
            S_DECODE: begin
                state_nx = S_EXEC;
            end
            S_EXEC: begin
                exec_en = 1'b1;
                mw_en   = mw;
                // Single register write per instruction, even across stalls.
                rw_en   = rw && complete;
                if (complete)
                    state_nx = halt_req ? S_HALT : S_FETCH;
            end
            S_HALT: begin
                halted = 1'b1;
                if (!halt_req)
                    state_nx = S_FETCH;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    assign imem_addr = pc;
    assign instr     = ir;

endmodule

// File: tb/tb_instr_sequencer.sv
// tb_instr_sequencer: directed-vector bench for instr_sequencer.
// Drives inputs and samples outputs 1 time unit after each rising edge.
module tb_instr_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_valid;
    logic [16:0] imem_data;
    logic [16:0] instr;
    logic [1:0]  bs;
    logic        ps;
    logic        zero;
    logic [7:0]  br_off;
    logic [7:0]  bus_a;
    logic        rw;
    logic        mw;
    logic        dmem_ready;
    logic        exec_en;
    logic        rw_en;
    logic        mw_en;
    logic        halt_req;
    logic        halted;
    logic [7:0]  pc;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    instr_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_valid (imem_valid),
        .imem_data  (imem_data),
        .instr      (instr),
        .bs         (bs),
        .ps         (ps),
        .zero       (zero),
        .br_off     (br_off),
        .bus_a      (bus_a),
        .rw         (rw),
        .mw         (mw),
        .dmem_ready (dmem_ready),
        .exec_en    (exec_en),
        .rw_en      (rw_en),
        .mw_en      (mw_en),
        .halt_req   (halt_req),
        .halted     (halted),
        .pc         (pc)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ctl(input logic [1:0] b, input logic p, input logic z,
                           input logic [7:0] off, input logic [7:0] a);
        bs     = b;
        ps     = p;
        zero   = z;
        br_off = off;
        bus_a  = a;
    endtask

    // Entered in FETCH with imem_valid=1; leaves in FETCH of the next instr.
    task automatic do_instr(input string tag, input logic [16:0] d,
                            input logic [7:0] a, input logic [7:0] n);
        imem_data  = d;
        imem_valid = 1'b1;
        #1;
        check({tag, "_req"}, imem_req, 1);
        check({tag, "_addr"}, imem_addr, a);
        tick();
        check({tag, "_dec_ir"}, instr, d);
        check({tag, "_dec_ex"}, exec_en, 0);
        tick();
        check({tag, "_ex"}, exec_en, 1);
        check({tag, "_ex_pc"}, pc, a);
        check({tag, "_ex_rw"}, rw_en, 0);
        tick();
        check({tag, "_pc"}, pc, n);
        check({tag, "_nx_ex"}, exec_en, 0);
        check({tag, "_nx_req"}, imem_req, 1);
    endtask

    initial begin
        rst        = 1'b1;
        imem_valid = 1'b0;
        imem_data  = '0;
        rw         = 1'b0;
        mw         = 1'b0;
        dmem_ready = 1'b1;
        halt_req   = 1'b0;
        set_ctl(2'b00, 1'b0, 1'b0, 8'h00, 8'h00);
        tick();
        tick();
        check("rst_pc", pc, 0);
        check("rst_ir", instr, 0);
        check("rst_req", imem_req, 0);
        check("rst_ex", exec_en, 0);
        check("rst_halt", halted, 0);
        check("rst_mw", mw_en, 0);

        // T1: cycle 0 is IDLE, fetches at cycles 1, 4, 7
        rst        = 1'b0;
        imem_valid = 1'b1;
        tick();
        do_instr("t1a", 17'h10001, 8'h00, 8'h01);
        do_instr("t1b", 17'h10002, 8'h01, 8'h02);
        do_instr("t1c", 17'h10003, 8'h02, 8'h03);

        // T2: conditional branch polarity
        set_ctl(2'b10, 1'b0, 1'b0, 8'h00, 8'h02);
        do_instr("jmp2", 17'h00010, 8'h03, 8'h02);
        set_ctl(2'b01, 1'b0, 1'b1, 8'h04, 8'h00);
        do_instr("t2a", 17'h00011, 8'h02, 8'h06);
        set_ctl(2'b10, 1'b0, 1'b0, 8'h00, 8'h02);
        do_instr("jmp2b", 17'h00012, 8'h06, 8'h02);
        set_ctl(2'b01, 1'b0, 1'b0, 8'h04, 8'h00);
        do_instr("t2b", 17'h00013, 8'h02, 8'h03);
        set_ctl(2'b10, 1'b0, 1'b0, 8'h00, 8'h02);
        do_instr("jmp2c", 17'h00014, 8'h03, 8'h02);
        set_ctl(2'b01, 1'b1, 1'b0, 8'h04, 8'h00);
        do_instr("t2c", 17'h00015, 8'h02, 8'h06);
        set_ctl(2'b01, 1'b1, 1'b1, 8'h04, 8'h00);
        do_instr("t2d", 17'h00016, 8'h06, 8'h07);

        // T3: register jump and unconditional backward branch
        set_ctl(2'b10, 1'b0, 1'b0, 8'h00, 8'h40);
        do_instr("t3a", 17'h00020, 8'h07, 8'h40);
        set_ctl(2'b10, 1'b0, 1'b0, 8'h00, 8'h05);
        do_instr("jmp5", 17'h00021, 8'h40, 8'h05);
        set_ctl(2'b11, 1'b0, 1'b0, 8'hFE, 8'h00);
        do_instr("t3b", 17'h00022, 8'h05, 8'h03);

        // T4: memory write stalled 3 cycles by dmem_ready
        set_ctl(2'b00, 1'b0, 1'b0, 8'h00, 8'h00);
        rw        = 1'b1;
        mw        = 1'b1;
        imem_data = 17'h00030;
        tick();
        check("t4_dec_ir", instr, 17'h00030);
        check("t4_dec_mw", mw_en, 0);
        tick();
        for (int k = 1; k <= 4; k++) begin
            dmem_ready = (k == 4);
            #1;
            check($sformatf("t4_ex%0d", k), exec_en, 1);
            check($sformatf("t4_mw%0d", k), mw_en, 1);
            check($sformatf("t4_rw%0d", k), rw_en, (k == 4) ? 1 : 0);
            check($sformatf("t4_pc%0d", k), pc, 8'h03);
            tick();
        end
        check("t4_pc", pc, 8'h04);
        check("t4_nx_ex", exec_en, 0);
        check("t4_nx_rw", rw_en, 0);
        rw         = 1'b0;
        mw         = 1'b0;
        dmem_ready = 1'b1;

        // T5: PC wrap and slow instruction memory
        set_ctl(2'b10, 1'b0, 1'b0, 8'h00, 8'hFF);
        do_instr("jmpff", 17'h00040, 8'h04, 8'hFF);
        set_ctl(2'b00, 1'b0, 1'b0, 8'h00, 8'h00);
        do_instr("t5w", 17'h00041, 8'hFF, 8'h00);
        imem_valid = 1'b0;
        imem_data  = 17'h1ABCD;
        for (int k = 0; k < 5; k++) begin
            #1;
            check($sformatf("t5_req%0d", k), imem_req, 1);
            check($sformatf("t5_ir%0d", k), instr, 17'h00041);
            tick();
        end
        do_instr("t5d", 17'h1ABCD, 8'h00, 8'h01);

        // T6: halt at instruction boundary, release, reset in FETCH
        imem_data = 17'h00050;
        tick();
        check("t6_dec", instr, 17'h00050);
        halt_req = 1'b1;
        tick();
        check("t6_ex", exec_en, 1);
        tick();
        check("t6_halt", halted, 1);
        check("t6_pc", pc, 8'h02);
        check("t6_h_req", imem_req, 0);
        check("t6_h_ex", exec_en, 0);
        tick();
        check("t6_hold", halted, 1);
        check("t6_hold_ir", instr, 17'h00050);
        halt_req = 1'b0;
        tick();
        check("t6_rel", halted, 0);
        check("t6_rel_req", imem_req, 1);
        check("t6_rel_addr", imem_addr, 8'h02);
        rst       = 1'b1;
        imem_data = 17'h00077;
        tick();
        check("t6_rst_pc", pc, 8'h00);
        check("t6_rst_ir", instr, 0);
        check("t6_rst_req", imem_req, 0);
        check("t6_rst_ex", exec_en, 0);
        rst = 1'b0;
        tick();
        check("idle_drop_ir", instr, 0);
        check("idle_fetch", imem_req, 1);

        // halt_req sampled in IDLE goes straight to HALT
        rst = 1'b1;
        tick();
        rst      = 1'b0;
        halt_req = 1'b1;
        tick();
        check("idle_halt", halted, 1);
        check("idle_halt_req", imem_req, 0);
        halt_req = 1'b0;
        tick();
        check("idle_rel", imem_req, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
